// File: rtl/fd_pkg.sv
// Shared definitions for the frame loader: FSM encoding, image geometry
// defaults and the SRAM address width.
package fd_pkg;

    localparam int IMG_W_DEF = 256;
    localparam int IMG_H_DEF = 128;
    localparam int ADDR_W    = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Address of the final pixel of a w x h frame.
    function automatic logic [ADDR_W-1:0] last_index(input int w, input int h);
        return ADDR_W'(w * h - 1);
    endfunction

endpackage

// File: rtl/fd_sram_wr_stage.sv
// One-deep write stage between the loader and the image SRAM. Holds the
// last address/data and raises the write enable for one cycle per accepted
// pixel.
module fd_sram_wr_stage
    import fd_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] sramAddr,
    output logic [7:0]        sramData,
    output logic              sramWren
);

    // Register the accepted pixel; reset discards any pending write at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sramAddr <= '0;
            sramData <= '0;
            sramWren <= 1'b0;
        end else begin
            sramWren <= wr_en;
            if (wr_en) begin
                sramAddr <= wr_addr;
                sramData <= wr_data;
            end
        end
    end

endmodule

// File: rtl/fd_img_loader.sv
// Streams one frame of pixels from a valid/ready source into the image SRAM
// in raster order, checking the frame length against IMG_W*IMG_H.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start; source not accepted
// ST_LOAD  | accepting pixels, one SRAM write per accept (1 cycle later)
// ST_FLUSH | last pending write completes; no more pixels accepted
// ST_DONE  | done pulses if the frame length matched, then back to idle
//
// The SRAM itself and the loader/detector address mux (selected by busy)
// live above this block.
module fd_img_loader
    import fd_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              pixValid,
    input  logic [7:0]        pixData,
    input  logic              pixLast,
    output logic              pixReady,
    output logic [ADDR_W-1:0] sramAddr,
    output logic [7:0]        sramData,
    output logic              sramWren,
    output logic              busy,
    output logic              done,
    output logic              frameErr
);

    localparam logic [ADDR_W-1:0] LAST_IDX = last_index(IMG_W, IMG_H);

    state_t            state;
    logic [ADDR_W-1:0] count;
    logic              accept;
    logic              at_last;

    // pixReady is only ever high in ST_LOAD, so it alone qualifies an accept.
    assign accept  = pixValid && pixReady;
    assign at_last = (count == LAST_IDX);

    // Sequencer, pixel counter and all registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            pixReady <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        count    <= '0;
                        frameErr <= 1'b0;
                        pixReady <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (pixLast || at_last) begin
                            // Count is left at the last index so it never wraps.
                            state    <= ST_FLUSH;
                            pixReady <= 1'b0;
                            if (pixLast != at_last) begin
                                frameErr <= 1'b1;
                            end
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= ~frameErr;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    pixReady <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    fd_sram_wr_stage u_wr_stage (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (accept),
        .wr_addr  (count),
        .wr_data  (pixData),
        .sramAddr (sramAddr),
        .sramData (sramData),
        .sramWren (sramWren)
    );

endmodule

// File: tb/tb_fd_img_loader.sv
// Directed bench for fd_img_loader with a 4x2 frame. Expected SRAM writes
// are queued as pixels are driven and matched against the write port.
module tb_fd_img_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        pixValid = 1'b0;
    logic [7:0]  pixData = 8'h00;
    logic        pixLast = 1'b0;
    logic        pixReady;
    logic [14:0] sramAddr;
    logic [7:0]  sramData;
    logic        sramWren;
    logic        busy;
    logic        done;
    logic        frameErr;

    int errors   = 0;
    int checks   = 0;
    int writes   = 0;
    int done_cnt = 0;
    logic [22:0] exp_q[$];

    fd_img_loader #(.IMG_W(4), .IMG_H(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .pixValid (pixValid),
        .pixData  (pixData),
        .pixLast  (pixLast),
        .pixReady (pixReady),
        .sramAddr (sramAddr),
        .sramData (sramData),
        .sramWren (sramWren),
        .busy     (busy),
        .done     (done),
        .frameErr (frameErr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Write-port scoreboard and done-pulse counter, sampled mid-cycle.
    always @(negedge clock) begin
        if (sramWren === 1'b1) begin
            writes++;
            chk("write_expected", (exp_q.size() != 0), 1);
            chk("write_in_range", (sramAddr < 15'd8), 1);
            if (exp_q.size() != 0) begin
                chk("write_addr_data", {9'd0, sramAddr, sramData}, {9'd0, exp_q.pop_front()});
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    // One frame: n pixels 0x10.., pixLast on pixel last_at (1-based, 0 = none),
    // optional idle gap between pixels, optional start pulse on pixel start_at,
    // optional extra pixel offered after the frame closes.
    task automatic run_frame(input int n, input int last_at, input bit gap,
                             input int start_at, input bit exp_err, input bit extra);
        int done_before;
        done_before = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_cleared", frameErr, 0);
        chk("ready_in_load", pixReady, 1);
        chk("busy_in_load", busy, 1);
        for (int i = 0; i < n; i++) begin
            pixValid = 1'b1;
            pixData  = 8'h10 + 8'(i);
            pixLast  = (i + 1 == last_at);
            start    = (i == start_at);
            chk("ready_pixel", pixReady, 1);
            exp_q.push_back({15'(i), 8'h10 + 8'(i)});
            tick();
            start = 1'b0;
            if (gap && i < n - 1) begin
                pixValid = 1'b0;
                pixData  = 8'hEE;
                chk("busy_stall", busy, 1);
                tick();
                chk("busy_after_stall", busy, 1);
            end
        end
        pixLast  = 1'b0;
        pixValid = extra;
        pixData  = 8'h18;
        chk("flush_ready", pixReady, 0);
        chk("flush_busy", busy, 1);
        chk("flush_done", done, 0);
        chk("flush_err", frameErr, exp_err);
        tick();
        chk("done_pulse", done, !exp_err);
        chk("done_busy", busy, 0);
        chk("done_ready", pixReady, 0);
        tick();
        chk("idle_done_low", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_err", frameErr, exp_err);
        pixValid = 1'b0;
        tick();
        chk("queue_drained", exp_q.size(), 0);
        chk("done_count", done_cnt - done_before, !exp_err);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_ready", pixReady, 0);
        chk("rst_wren", sramWren, 0);
        chk("rst_addr", sramAddr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", frameErr, 0);
        reset = 1'b0;
        // Source presenting in IDLE must not be accepted
        pixValid = 1'b1;
        pixData  = 8'h55;
        tick();
        tick();
        chk("idle_ready", pixReady, 0);
        chk("idle_no_write", writes, 0);
        pixValid = 1'b0;
        tick();

        // Nominal back-to-back frame
        run_frame(8, 8, 1'b0, -1, 1'b0, 1'b0);
        // pixValid toggling every other cycle
        run_frame(8, 8, 1'b1, -1, 1'b0, 1'b0);
        // Short frame: pixLast on the 5th pixel
        run_frame(5, 5, 1'b0, -1, 1'b1, 1'b0);
        // Long frame: 8 pixels without pixLast, a 9th offered and refused
        run_frame(8, 0, 1'b0, -1, 1'b1, 1'b1);

        // Reset right after the 3rd accept drops its pending write
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pixValid = 1'b1;
            pixData  = 8'h30 + 8'(i);
            if (i < 2) exp_q.push_back({15'(i), 8'h30 + 8'(i)});
            tick();
        end
        reset = 1'b1;
        #1;
        chk("mid_rst_wren", sramWren, 0);
        chk("mid_rst_addr", sramAddr, 0);
        chk("mid_rst_data", sramData, 0);
        chk("mid_rst_ready", pixReady, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", frameErr, 0);
        pixValid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("post_rst_writes", writes, 8 + 8 + 5 + 8 + 2);
        chk("post_rst_queue", exp_q.size(), 0);
        run_frame(8, 8, 1'b0, -1, 1'b0, 1'b0);

        // start pulsed mid-LOAD has no effect
        run_frame(8, 8, 1'b0, 3, 1'b0, 1'b0);

        tick();
        chk("total_writes", writes, 8 + 8 + 5 + 8 + 2 + 8 + 8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fd_img_loader.md
FD_IMG_LOADER -- requirements
Module: fd_img_loader

Interface
REQ-001 SHALL have parameter IMG_W, default 256, meaning pixels per image row.
REQ-002 SHALL have parameter IMG_H, default 128, meaning rows per frame; IMG_W*IMG_H SHALL be at most 32768.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a single-cycle request to begin loading a frame.
REQ-006 SHALL have port pixValid, input, 1, meaning the source presents a pixel.
REQ-007 SHALL have port pixData, input, 8, the pixel value.
REQ-008 SHALL have port pixLast, input, 1, which the source asserts with the final pixel of the frame.
REQ-009 SHALL have port pixReady, output, 1, meaning the loader accepts a pixel this cycle.
REQ-010 SHALL have port sramAddr, output, 15, the image SRAM write address.
REQ-011 SHALL have port sramData, output, 8, the image SRAM write data.
REQ-012 SHALL have port sramWren, output, 1, the image SRAM write enable.
REQ-013 SHALL have port busy, output, 1, high while a frame is being loaded.
REQ-014 SHALL have port done, output, 1, a one-cycle pulse when a frame load completes correctly; it releases the detector.
REQ-015 SHALL have port frameErr, output, 1, a sticky flag for a length mismatch.

Function
REQ-016 SHALL use the FSM states IDLE, LOAD, FLUSH and DONE.
REQ-017 IDLE: pixReady SHALL be 0; start SHALL clear frameErr and the pixel counter and move to LOAD.
REQ-018 LOAD: pixReady SHALL be 1; a pixel is accepted when pixValid&&pixReady.
REQ-019 Each accepted pixel SHALL be registered and written one cycle later, with sramWren=1, sramAddr=count and sramData=pixData; write latency is 1 cycle.
REQ-020 count SHALL increment by 1 per accepted pixel, so address = row*IMG_W + col in raster order.
REQ-021 An accepted pixel with pixLast=1 and count==IMG_W*IMG_H-1 SHALL move the FSM to FLUSH.
REQ-022 An accepted pixel with pixLast=1 and count<IMG_W*IMG_H-1 (short frame) SHALL set frameErr, move to FLUSH and suppress done.
REQ-023 An accepted pixel at count==IMG_W*IMG_H-1 with pixLast=0 (long frame) SHALL set frameErr and move to FLUSH; later pixels SHALL NOT be accepted.
REQ-024 The address SHALL never wrap; no write SHALL occur at an address of IMG_W*IMG_H or above.
REQ-025 FLUSH: pixReady SHALL be 0; the final pending write SHALL complete this cycle; then move to DONE.
REQ-026 DONE: done SHALL be 1 for exactly one cycle if frameErr=0, else 0; then move to IDLE.
REQ-027 busy SHALL be 1 in LOAD and FLUSH, and 0 otherwise.
REQ-028 start SHALL be ignored outside IDLE.
REQ-029 A cycle with pixValid=0 in LOAD SHALL stall with no write and no count change.
REQ-030 sramWren SHALL be 0 in every cycle with no pending accepted pixel.

Reset
REQ-031 On reset the FSM SHALL go to IDLE, count=0, sramAddr=0, sramData=0, sramWren=0, pixReady=0, busy=0, done=0 and frameErr=0, asynchronously.
REQ-032 Reset during LOAD SHALL drop any pending write immediately; no partial write SHALL follow the deassertion of reset.

Structure
REQ-033 A shared package fd_pkg SHALL hold the FSM state encoding, the IMG_W/IMG_H defaults and the address width constant (15).
REQ-034 The write-stage register (addr/data/wren) SHALL be one sub-module, fd_sram_wr_stage; the FSM and counter stay in fd_img_loader.
REQ-035 The SRAM instance SHALL be outside this block; the top level muxes the SRAM address between loader and detector using busy.

Verification
REQ-036 IMG_W=4, IMG_H=2: start, then 8 back-to-back pixels 0x10..0x17 with pixLast on the 8th -> writes to addr 0..7 with data 0x10..0x17, done pulses once 2 cycles after the last accept, and frameErr=0.
REQ-037 The same frame with pixValid toggling every other cycle -> the identical write sequence with no duplicate or missing writes, and busy held high throughout.
REQ-038 pixLast on the 5th pixel -> writes to addr 0..4 only, frameErr=1, no done, and the FSM returns to IDLE.
REQ-039 9 pixels with no pixLast -> 8 writes, pixReady=0 after the 8th accept, frameErr=1, and the 9th pixel is never written.
REQ-040 reset asserted after the 3rd accept -> all outputs 0 in the same cycle, no further writes, and a new start loads correctly from addr 0.
REQ-041 start pulsed mid-LOAD -> no effect: count continues and done still occurs once.
